sysclk_phase_gen: RTL

- Parametrised successor to the TURF sysclk phase/sync generator.
- Runs a free-running command-period phase counter on sysclk and produces period-start and phase flags, plus NCHAN sync toggles, each with its own programmable phase offset.
- A req/ack handshake realigns the counter to a commanded phase at the next period boundary.
- Sits between the sysclk MMCM/BUFG and the command/trigger logic, and drives the GPIO SYNC IOB flops.

---
 rtl/sysclk_pkg.sv | 13 +
 rtl/sysclk_sync_chan.sv | 44 ++++
 rtl/sysclk_phase_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sysclk_pkg.sv
// Shared types and constants for the sysclk phase/sync generator.
package sysclk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_LOW = 2'd2
  } align_state_t;

  localparam int MONITOR_LOCK_COUNT = 4;
  localparam int MISMATCH_BITS      = 8;

endpackage

// File: rtl/sysclk_sync_chan.sv
// One sync toggle channel: enable/offset config register plus the toggle flop.
module sysclk_sync_chan
  import sysclk_pkg::*;
#(
  parameter int PHASE_BITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_cfg_wr,
  input  logic                  i_cfg_en,
  input  logic [PHASE_BITS-1:0] i_cfg_offset,
  input  logic [PHASE_BITS-1:0] i_phase,
  input  logic                  i_clear,
  output logic                  o_sync
);

  logic                  r_en;
  logic [PHASE_BITS-1:0] r_offset;
  logic                  r_sync;

  // The toggle decision uses the config as registered before this edge, so a
  // write only takes effect from the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en     <= 1'b0;
      r_offset <= '0;
      r_sync   <= 1'b0;
    end else if (i_run) begin
      if (i_cfg_wr) begin
        r_en     <= i_cfg_en;
        r_offset <= i_cfg_offset;
      end
      if (i_clear || !r_en) begin
        r_sync <= 1'b0;
      end else if (i_phase == r_offset) begin
        r_sync <= ~r_sync;
      end
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sysclk_phase_gen.sv
// Command-period phase counter, epoch counter, per-channel sync toggles and align handshake.
// Optional sync monitor enabled by defining SYSCLK_PHASE_GEN_SYNC_MONITOR_EN.
module sysclk_phase_gen
  import sysclk_pkg::*;
#(
  parameter int PHASE_BITS = 3,
  parameter int NCHAN      = 2,
  parameter int EPOCH_BITS = 16
) (
  input  logic                     sysclk_i,
  input  logic                     reset_n,
  input  logic                     cfg_wr_i,
  input  logic [2:0]               cfg_chan_i,
  input  logic                     cfg_en_i,
  input  logic [PHASE_BITS-1:0]    cfg_offset_i,
  input  logic                     align_req_i,
  input  logic [PHASE_BITS-1:0]    align_phase_i,
  output logic                     align_ack_o,
  output logic [PHASE_BITS-1:0]    phase_o,
  output logic                     period_start_o,
  output logic [EPOCH_BITS-1:0]    epoch_o,
  output logic [NCHAN-1:0]         sync_o,
  input  logic                     sync_ref_i,
  output logic [MISMATCH_BITS-1:0] mismatch_cnt_o,
  output logic                     locked_o
);

  localparam logic [PHASE_BITS-1:0] PHASE_MAX = '1;

  logic                  r_run;
  logic [PHASE_BITS-1:0] r_phase;
  logic [EPOCH_BITS-1:0] r_epoch;
  logic [PHASE_BITS-1:0] r_align_phase;
  logic                  r_ack;
  align_state_t          r_state;

  logic w_wrap;
  logic w_apply;

  assign w_wrap  = (r_phase == PHASE_MAX);
  assign w_apply = (r_state == ARMED) && w_wrap;

  // r_run rises on the first edge after release, so counting starts on the second.
  always_ff @(posedge sysclk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_run         <= 1'b0;
      r_phase       <= '0;
      r_epoch       <= '0;
      r_align_phase <= '0;
      r_ack         <= 1'b0;
      r_state       <= IDLE;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      if (w_apply) begin
        r_phase <= r_align_phase;
        r_epoch <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
        if (w_wrap) r_epoch <= r_epoch + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (align_req_i) begin
            r_align_phase <= align_phase_i;
            r_state       <= ARMED;
          end
        end
        ARMED: begin
          if (w_wrap) begin
            r_ack   <= 1'b1;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!align_req_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign phase_o        = r_phase;
  assign period_start_o = (r_phase == '0);
  assign epoch_o        = r_epoch;
  assign align_ack_o    = r_ack;

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    logic w_chan_wr;
    assign w_chan_wr = cfg_wr_i && (cfg_chan_i == 3'(k));

    sysclk_sync_chan #(
      .PHASE_BITS (PHASE_BITS)
    ) u_chan (
      .i_clk        (sysclk_i),
      .i_rst_n      (reset_n),
      .i_run        (r_run),
      .i_cfg_wr     (w_chan_wr),
      .i_cfg_en     (cfg_en_i),
      .i_cfg_offset (cfg_offset_i),
      .i_phase      (r_phase),
      .i_clear      (w_apply),
      .o_sync       (sync_o[k])
    );
  end

`ifdef SYSCLK_PHASE_GEN_SYNC_MONITOR_EN
  localparam int RUN_W = $clog2(MONITOR_LOCK_COUNT + 1);

  logic [MISMATCH_BITS-1:0] r_mismatch;
  logic [RUN_W-1:0]         r_match_run;
  logic                     r_locked;
  logic                     w_mismatch;

  assign w_mismatch = (sync_ref_i != sync_o[0]);

  // The match run saturates one short of the lock count; the next match locks.
  always_ff @(posedge sysclk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_mismatch  <= '0;
      r_match_run <= '0;
      r_locked    <= 1'b0;
    end else if (r_run) begin
      if (w_apply) begin
        r_mismatch <= '0;
      end else if (period_start_o && w_mismatch && (r_mismatch != '1)) begin
        r_mismatch <= r_mismatch + 1'b1;
      end
      if (period_start_o) begin
        if (w_mismatch) begin
          r_locked    <= 1'b0;
          r_match_run <= '0;
        end else if (r_match_run == RUN_W'(MONITOR_LOCK_COUNT - 1)) begin
          r_locked <= 1'b1;
        end else begin
          r_match_run <= r_match_run + 1'b1;
        end
      end
    end
  end

  assign mismatch_cnt_o = r_mismatch;
  assign locked_o       = r_locked;
`else
  logic w_unused_sync_ref;
  assign w_unused_sync_ref = sync_ref_i;
  assign mismatch_cnt_o    = '0;
  assign locked_o          = 1'b1;
`endif

endmodule
